// File: rtl/subleq_pkg.sv
// Shared definitions for the SUBLEQ core: default widths, FSM state encoding
// and the branch-to-self halt test.
package subleq_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_A,
    S_FETCH_B,
    S_FETCH_C,
    S_READ_A,
    S_READ_B,
    S_WRITE_B,
    S_HALT
  } state_e;

  // A taken branch whose target is the current instruction halts the core.
  function automatic logic is_halt(
    input logic        leq,
    input logic [31:0] tgt,
    input logic [31:0] cur_pc
  );
    return leq && (tgt == cur_pc);
  endfunction

endpackage

// File: rtl/subleq_alu.sv
// SUBLEQ subtractor: diff = b - a (mod 2^DATA_W), leq = diff <= 0 signed.
// Ports: a (mem[A]), b (mem[B]) in; diff, leq out.
module subleq_alu
  import subleq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] diff,
  output logic              leq
);

  assign diff = b - a;
  assign leq  = diff[DATA_W-1] | (diff == '0);

endmodule

// File: rtl/subleq_core.sv
// SUBLEQ core: mem[B] -= mem[A]; branch to C if result <= 0, else pc += 3.
// Ports: clk/res, start/busy/halted, pc, req/ack memory bus, instr_cnt.
// Macro SUBLEQ_PERF_EN enables the saturating retired-instruction counter.
module subleq_core
  import subleq_pkg::*;
#(
  parameter int              DATA_W   = DEF_DATA_W,
  parameter int              ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  output logic              busy,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       instr_cnt
);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] opa_q, opa_d;
  logic [ADDR_W-1:0] opb_q, opb_d;
  logic [ADDR_W-1:0] opc_q, opc_d;
  logic [DATA_W-1:0] va_q, va_d;
  logic [DATA_W-1:0] vb_q, vb_d;

  logic [DATA_W-1:0] diff;
  logic              leq;
  logic              halt_hit;

  subleq_alu #(.DATA_W(DATA_W)) u_alu (
    .a    (va_q),
    .b    (vb_q),
    .diff (diff),
    .leq  (leq)
  );

  assign halt_hit = is_halt(leq, 32'(opc_q), 32'(pc_q));

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      opa_q   <= '0;
      opb_q   <= '0;
      opc_q   <= '0;
      va_q    <= '0;
      vb_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      opc_q   <= opc_d;
      va_q    <= va_d;
      vb_q    <= vb_d;
    end
  end

  // Bus outputs are decoded from registered state only, so they
  // stay stable across wait cycles and drop to zero on reset.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    opc_d     = opc_q;
    va_d      = va_q;
    vb_d      = vb_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_FETCH_A;
          pc_d    = RESET_PC;
        end
      end
      S_FETCH_A: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ack) begin
          opa_d   = mem_rdata[ADDR_W-1:0];
          state_d = S_FETCH_B;
        end
      end
      S_FETCH_B: begin
        mem_req  = 1'b1;
        mem_addr = pc_q + ADDR_W'(1);
        if (mem_ack) begin
          opb_d   = mem_rdata[ADDR_W-1:0];
          state_d = S_FETCH_C;
        end
      end
      S_FETCH_C: begin
        mem_req  = 1'b1;
        mem_addr = pc_q + ADDR_W'(2);
        if (mem_ack) begin
          opc_d   = mem_rdata[ADDR_W-1:0];
          state_d = S_READ_A;
        end
      end
      S_READ_A: begin
        mem_req  = 1'b1;
        mem_addr = opa_q;
        if (mem_ack) begin
          va_d    = mem_rdata;
          state_d = S_READ_B;
        end
      end
      S_READ_B: begin
        mem_req  = 1'b1;
        mem_addr = opb_q;
        if (mem_ack) begin
          vb_d    = mem_rdata;
          state_d = S_WRITE_B;
        end
      end
      S_WRITE_B: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = opb_q;
        mem_wdata = diff;
        if (mem_ack) begin
          if (halt_hit) begin
            state_d = S_HALT;
          end else begin
            state_d = S_FETCH_A;
            pc_d    = leq ? opc_q : pc_q + ADDR_W'(3);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy   = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted = (state_q == S_HALT);
  assign pc     = pc_q;

`ifdef SUBLEQ_PERF_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_WRITE_B && mem_ack && cnt_q != '1) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign instr_cnt = cnt_q;
`else
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_subleq_core.sv
// Directed bench for subleq_core: two instances (RESET_PC 0 and 8'hFD)
// share one single-port memory model with programmable wait states.
module tb_subleq_core;

`ifdef SUBLEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic res;
  logic start0, start1;
  logic sel;
  int   wait_n;
  int   wcnt = 0;

  logic        busy0, halted0, req0, we0, ack0;
  logic [7:0]  pc0, addr0, wdata0;
  logic [31:0] cnt0;
  logic        busy1, halted1, req1, we1, ack1;
  logic [7:0]  pc1, addr1, wdata1;
  logic [31:0] cnt1;

  logic        m_req, m_we, m_ack;
  logic [7:0]  m_addr, m_wdata, rdata;
  logic [7:0]  mem [256];
  logic        ld_en;
  logic [7:0]  ld_addr, ld_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  subleq_core #(.DATA_W(8), .ADDR_W(8), .RESET_PC(8'h00)) u0 (
    .clk(clk), .res(res), .start(start0),
    .busy(busy0), .halted(halted0), .pc(pc0),
    .mem_req(req0), .mem_we(we0), .mem_addr(addr0),
    .mem_wdata(wdata0), .mem_rdata(rdata), .mem_ack(ack0),
    .instr_cnt(cnt0)
  );

  subleq_core #(.DATA_W(8), .ADDR_W(8), .RESET_PC(8'hFD)) u1 (
    .clk(clk), .res(res), .start(start1),
    .busy(busy1), .halted(halted1), .pc(pc1),
    .mem_req(req1), .mem_we(we1), .mem_addr(addr1),
    .mem_wdata(wdata1), .mem_rdata(rdata), .mem_ack(ack1),
    .instr_cnt(cnt1)
  );

  always_comb begin
    m_req   = sel ? req1 : req0;
    m_we    = sel ? we1 : we0;
    m_addr  = sel ? addr1 : addr0;
    m_wdata = sel ? wdata1 : wdata0;
    m_ack   = m_req && (wcnt == wait_n);
    ack0    = !sel && m_ack;
    ack1    = sel && m_ack;
    rdata   = mem[m_addr];
  end

  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (m_ack && m_we) begin
      mem[m_addr] <= m_wdata;
    end
    if (m_req && !m_ack) wcnt <= wcnt + 1;
    else                 wcnt <= 0;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  task automatic load_instr(input logic [7:0] base,
                            input logic [7:0] a,
                            input logic [7:0] b,
                            input logic [7:0] c);
    load(base, a);
    load(base + 8'd1, b);
    load(base + 8'd2, c);
  endtask

  task automatic do_reset();
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
  endtask

  task automatic go0();
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  logic       p_req, p_ack, p_we;
  logic [7:0] p_addr, p_wdata;

  initial begin
    res = 1'b1; start0 = 1'b0; start1 = 1'b0;
    sel = 1'b0; wait_n = 0; ld_en = 1'b0;
    ld_addr = '0; ld_data = '0;
    @(negedge clk);
    check("rst_pc0", 32'(pc0), 32'h00);
    check("rst_pc1", 32'(pc1), 32'hFD);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_halted", 32'(halted0), 32'd0);
    check("rst_req", 32'(req0), 32'd0);
    check("rst_we", 32'(we0), 32'd0);
    check("rst_addr", 32'(addr0), 32'd0);
    check("rst_wdata", 32'(wdata0), 32'd0);
    check("rst_cnt", cnt0, 32'd0);
    res = 1'b0;

    // 1: basic non-leq instruction, start while busy ignored
    load_instr(8'd0, 8'd3, 8'd4, 8'd0);
    load(8'd3, 8'd5);
    load(8'd4, 8'd7);
    go0();
    check("t1_busy", 32'(busy0), 32'd1);
    check("t1_fa_addr", 32'(addr0), 32'd0);
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (3) @(negedge clk);
    check("t1_pc_mid", 32'(pc0), 32'd0);
    @(negedge clk);
    check("t1_mem4", 32'(mem[4]), 32'd2);
    check("t1_pc", 32'(pc0), 32'd3);
    check("t1_next_addr", 32'(addr0), 32'd3);
    check("t1_cnt", cnt0, PERF ? 32'd1 : 32'd0);
    do_reset();

    // 2: branch to self halts; restart from HALT
    load_instr(8'd0, 8'd6, 8'd6, 8'd0);
    load(8'd6, 8'd9);
    go0();
    repeat (6) @(negedge clk);
    check("t2_halted", 32'(halted0), 32'd1);
    check("t2_busy", 32'(busy0), 32'd0);
    check("t2_req", 32'(req0), 32'd0);
    check("t2_mem6", 32'(mem[6]), 32'd0);
    check("t2_pc", 32'(pc0), 32'd0);
    check("t2_cnt", cnt0, PERF ? 32'd1 : 32'd0);
    go0();
    check("t2_re_busy", 32'(busy0), 32'd1);
    check("t2_re_halted", 32'(halted0), 32'd0);
    repeat (6) @(negedge clk);
    check("t2_re_halt", 32'(halted0), 32'd1);
    check("t2_re_cnt", cnt0, PERF ? 32'd2 : 32'd0);
    do_reset();

    // 3: three wait cycles per access
    load_instr(8'd0, 8'd3, 8'd4, 8'd0);
    load(8'd3, 8'd5);
    load(8'd4, 8'd7);
    wait_n = 3;
    go0();
    for (int i = 0; i < 24; i++) begin
      p_req = req0; p_ack = ack0; p_we = we0;
      p_addr = addr0; p_wdata = wdata0;
      @(negedge clk);
      if (p_req && !p_ack) begin
        check("t3_req_hold", 32'(req0), 32'd1);
        check("t3_addr_hold", 32'(addr0), 32'(p_addr));
        check("t3_we_hold", 32'(we0), 32'(p_we));
        check("t3_wd_hold", 32'(wdata0), 32'(p_wdata));
      end
      if (i == 21) begin
        check("t3_wb_we", 32'(we0), 32'd1);
        check("t3_wb_addr", 32'(addr0), 32'd4);
        check("t3_wb_wdata", 32'(wdata0), 32'd2);
      end
      if (i == 22) check("t3_pc_mid", 32'(pc0), 32'd0);
    end
    check("t3_pc", 32'(pc0), 32'd3);
    check("t3_mem4", 32'(mem[4]), 32'd2);
    wait_n = 0;
    do_reset();

    // 4: pc wraps past 8'hFF
    load_instr(8'hFD, 8'h10, 8'h11, 8'h20);
    load(8'h10, 8'd1);
    load(8'h11, 8'd5);
    sel = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("t4_a_fd", 32'(addr1), 32'hFD);
    @(negedge clk);
    check("t4_a_fe", 32'(addr1), 32'hFE);
    @(negedge clk);
    check("t4_a_ff", 32'(addr1), 32'hFF);
    repeat (4) @(negedge clk);
    check("t4_mem11", 32'(mem[8'h11]), 32'd4);
    check("t4_pc", 32'(pc1), 32'h00);
    check("t4_a_00", 32'(addr1), 32'h00);
    @(negedge clk);
    check("t4_a_01", 32'(addr1), 32'h01);
    @(negedge clk);
    check("t4_a_02", 32'(addr1), 32'h02);
    do_reset();
    sel = 1'b0;

    // 5: reset during READ_B, then rerun
    load_instr(8'd0, 8'd3, 8'd4, 8'd0);
    load(8'd3, 8'd5);
    load(8'd4, 8'd7);
    go0();
    repeat (4) @(negedge clk);
    check("t5_rb_addr", 32'(addr0), 32'd4);
    check("t5_rb_req", 32'(req0), 32'd1);
    res = 1'b1;
    #1;
    check("t5_req", 32'(req0), 32'd0);
    check("t5_pc", 32'(pc0), 32'd0);
    check("t5_busy", 32'(busy0), 32'd0);
    check("t5_addr", 32'(addr0), 32'd0);
    @(negedge clk);
    res = 1'b0;
    check("t5_mem4_kept", 32'(mem[4]), 32'd7);
    go0();
    repeat (6) @(negedge clk);
    check("t5_mem4", 32'(mem[4]), 32'd2);
    check("t5_pc_after", 32'(pc0), 32'd3);
    do_reset();

    // 6: sign handling of diff
    load_instr(8'd0, 8'd3, 8'd4, 8'h20);
    load(8'd3, 8'h01);
    load(8'd4, 8'h80);
    go0();
    repeat (6) @(negedge clk);
    check("t6_pos_mem", 32'(mem[4]), 32'h7F);
    check("t6_pos_pc", 32'(pc0), 32'd3);
    do_reset();
    load(8'd4, 8'h00);
    go0();
    repeat (6) @(negedge clk);
    check("t6_neg_mem", 32'(mem[4]), 32'hFF);
    check("t6_neg_pc", 32'(pc0), 32'h20);
    check("t6_neg_halt", 32'(halted0), 32'd0);
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
